// File: rtl/mmu_ptw.sv
// mmu_ptw: round-robin translation front end with a fully-associative TLB and a two-level page-table walker.
// Optional hit/miss counters are built when MMU_PERF_CNT_EN is defined.
module mmu_ptw #(
  parameter int NUM_CH      = 2,
  parameter int TLB_ENTRIES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           start_entry_cata,
  input  logic [31:0]           config_i,
  input  logic                  flush_i,
  input  logic [NUM_CH-1:0]     req_i,
  input  logic [32*NUM_CH-1:0]  req_vaddr_i,
  output logic [NUM_CH-1:0]     req_ack_o,
  output logic [NUM_CH-1:0]     resp_valid_o,
  output logic [31:0]           resp_paddr_o,
  output logic                  resp_except_o,
  output logic [31:0]           addr_mem_o,
  output logic                  valid_mem_o,
  input  logic [31:0]           data_mem_i,
  input  logic                  valid_mem_i,
  input  logic                  busy_mem_i,
  output logic [2:0]            state
`ifdef MMU_PERF_CNT_EN
  ,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
`endif
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int EW = $clog2(TLB_ENTRIES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    L1_REQ  = 3'd2,
    L1_WAIT = 3'd3,
    L2_REQ  = 3'd4,
    L2_WAIT = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t                  cur_r, nxt_s;
  logic [CW-1:0]           rr_r, gnt_r, gnt_s, cand_s;
  logic                    any_req_s;
  logic [31:0]             vaddr_r, vsel_s;
  logic [31:0]             res_paddr_r;
  logic                    res_except_r;
  logic                    walk_flush_r;
  logic [TLB_ENTRIES-1:0]  tlb_valid_r;
  logic [19:0]             tlb_tag_r [TLB_ENTRIES];
  logic [19:0]             tlb_pfn_r [TLB_ENTRIES];
  logic [EW-1:0]           repl_r;
  logic                    hit_s;
  logic [19:0]             hit_pfn_s;
  logic                    refill_s;
  logic                    unused_s;

  assign state    = cur_r;
  assign unused_s = ^{config_i[31:1], start_entry_cata[11:0], data_mem_i[11:1]};

  // Round-robin pick: scan downward so the lowest offset from rr_r wins.
  always_comb begin
    any_req_s = 1'b0;
    gnt_s     = '0;
    cand_s    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand_s = CW'((int'(rr_r) + i) % NUM_CH);
      if (req_i[cand_s]) begin
        any_req_s = 1'b1;
        gnt_s     = cand_s;
      end else begin
        any_req_s = any_req_s;
      end
    end
  end

  // Virtual address of the channel being granted.
  always_comb begin
    vsel_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt_s == CW'(c)) vsel_s = req_vaddr_i[32*c +: 32];
      else                 vsel_s = vsel_s;
    end
  end

  // Associative TLB match against the latched VPN.
  always_comb begin
    hit_s     = 1'b0;
    hit_pfn_s = '0;
    for (int e = 0; e < TLB_ENTRIES; e++) begin
      if (tlb_valid_r[e] && (tlb_tag_r[e] == vaddr_r[31:12])) begin
        hit_s     = 1'b1;
        hit_pfn_s = tlb_pfn_r[e];
      end else begin
        hit_s = hit_s;
      end
    end
  end

  assign refill_s = (cur_r == L2_WAIT) && valid_mem_i && data_mem_i[0] && !walk_flush_r && !flush_i;

  // Next-state logic.
  always_comb begin
    nxt_s = cur_r;
    case (cur_r)
      IDLE:    if (any_req_s) nxt_s = LOOKUP; else nxt_s = IDLE;
      LOOKUP:  if (!config_i[0] || hit_s) nxt_s = DONE; else nxt_s = L1_REQ;
      L1_REQ:  if (!busy_mem_i) nxt_s = L1_WAIT; else nxt_s = L1_REQ;
      L1_WAIT: if (valid_mem_i) nxt_s = data_mem_i[0] ? L2_REQ : DONE; else nxt_s = L1_WAIT;
      L2_REQ:  if (!busy_mem_i) nxt_s = L2_WAIT; else nxt_s = L2_REQ;
      L2_WAIT: if (valid_mem_i) nxt_s = DONE; else nxt_s = L2_WAIT;
      DONE:    nxt_s = IDLE;
      default: nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_r <= IDLE;
    else     cur_r <= nxt_s;
  end

  // Datapath, handshake outputs and TLB bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_r          <= '0;
      gnt_r         <= '0;
      vaddr_r       <= '0;
      res_paddr_r   <= '0;
      res_except_r  <= 1'b0;
      walk_flush_r  <= 1'b0;
      tlb_valid_r   <= '0;
      repl_r        <= '0;
      req_ack_o     <= '0;
      resp_valid_o  <= '0;
      resp_paddr_o  <= '0;
      resp_except_o <= 1'b0;
      addr_mem_o    <= '0;
      valid_mem_o   <= 1'b0;
    end else begin
      req_ack_o    <= '0;
      resp_valid_o <= '0;
      if (flush_i)       tlb_valid_r         <= '0;
      else if (refill_s) tlb_valid_r[repl_r] <= 1'b1;
      if (refill_s) repl_r <= repl_r + 1'b1;
      if (flush_i && (cur_r inside {L1_REQ, L1_WAIT, L2_REQ, L2_WAIT})) walk_flush_r <= 1'b1;
      case (cur_r)
        IDLE: if (any_req_s) begin
          req_ack_o[gnt_s] <= 1'b1;
          gnt_r            <= gnt_s;
          vaddr_r          <= vsel_s;
          walk_flush_r     <= 1'b0;
          rr_r             <= (gnt_s == CW'(NUM_CH - 1)) ? '0 : gnt_s + 1'b1;
        end
        LOOKUP: begin
          if (!config_i[0]) begin
            res_paddr_r  <= vaddr_r;
            res_except_r <= 1'b0;
          end else if (hit_s) begin
            res_paddr_r  <= {hit_pfn_s, vaddr_r[11:0]};
            res_except_r <= 1'b0;
          end else begin
            valid_mem_o <= 1'b1;
            addr_mem_o  <= {start_entry_cata[31:12], vaddr_r[31:22], 2'b00};
          end
        end
        L1_REQ, L2_REQ: if (!busy_mem_i) valid_mem_o <= 1'b0;
        L1_WAIT: if (valid_mem_i) begin
          if (!data_mem_i[0]) begin
            res_paddr_r  <= vaddr_r;
            res_except_r <= 1'b1;
          end else begin
            valid_mem_o <= 1'b1;
            addr_mem_o  <= {data_mem_i[31:12], vaddr_r[21:12], 2'b00};
          end
        end
        L2_WAIT: if (valid_mem_i) begin
          res_paddr_r  <= data_mem_i[0] ? {data_mem_i[31:12], vaddr_r[11:0]} : vaddr_r;
          res_except_r <= !data_mem_i[0];
        end
        DONE: begin
          resp_valid_o[gnt_r] <= 1'b1;
          resp_paddr_o        <= res_paddr_r;
          resp_except_o       <= res_except_r;
        end
        default: valid_mem_o <= 1'b0;
      endcase
    end
  end

  // TLB tag/PFN storage; qualified by tlb_valid_r so it needs no reset.
  always_ff @(posedge clk) begin
    if (refill_s) begin
      tlb_tag_r[repl_r] <= vaddr_r[31:12];
      tlb_pfn_r[repl_r] <= data_mem_i[31:12];
    end
  end

`ifdef MMU_PERF_CNT_EN
  // Saturating hit/miss counters for translation-enabled lookups.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_o  <= 32'd0;
      miss_cnt_o <= 32'd0;
    end else if ((cur_r == LOOKUP) && config_i[0]) begin
      if (hit_s && (hit_cnt_o != 32'hFFFF_FFFF))   hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (!hit_s && (miss_cnt_o != 32'hFFFF_FFFF)) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mmu_ptw.sv
// Scoreboard bench for mmu_ptw: requests push expected responses, a monitor pops and compares them.
module tb_mmu_ptw;

  logic        clk, rst;
  logic [31:0] start_entry_cata, config_i;
  logic        flush_i;
  logic [1:0]  req_i;
  logic [63:0] req_vaddr_i;
  logic [1:0]  req_ack_o, resp_valid_o;
  logic [31:0] resp_paddr_o, addr_mem_o, data_mem_i;
  logic        resp_except_o, valid_mem_o, valid_mem_i, busy_mem_i;
  logic [2:0]  state;

  mmu_ptw #(.NUM_CH(2), .TLB_ENTRIES(8)) dut (
    .clk(clk), .rst(rst), .start_entry_cata(start_entry_cata), .config_i(config_i),
    .flush_i(flush_i), .req_i(req_i), .req_vaddr_i(req_vaddr_i), .req_ack_o(req_ack_o),
    .resp_valid_o(resp_valid_o), .resp_paddr_o(resp_paddr_o), .resp_except_o(resp_except_o),
    .addr_mem_o(addr_mem_o), .valid_mem_o(valid_mem_o), .data_mem_i(data_mem_i),
    .valid_mem_i(valid_mem_i), .busy_mem_i(busy_mem_i), .state(state)
  );

  typedef struct {int ch; logic [31:0] pa; logic ex;} exp_t;
  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int pass_cnt = 0, tot_cnt = 0;
  int cyc = 0, resp_cnt = 0, resp_cyc = 0, mem_reads = 0;
  int lat, mr, k, r0;

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    case (a)
      32'h0010_0004: return 32'h0020_0001;
      32'h0020_000C: return 32'h0ABC_D001;
      32'h0010_0008: return 32'h0030_0000;
      32'h0020_0010: return 32'h0555_5001;
      32'h0020_0014: return 32'h0666_6001;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  // Memory: accept when valid && !busy, answer one cycle later.
  initial begin
    logic [31:0] a;
    valid_mem_i = 1'b0;
    data_mem_i  = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst && valid_mem_o && !busy_mem_i) begin
        a = addr_mem_o;
        mem_reads++;
        addr_q.push_back(a);
        @(posedge clk); #1;
        data_mem_i  = mem_lookup(a);
        valid_mem_i = 1'b1;
        @(posedge clk); #1;
        valid_mem_i = 1'b0;
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && resp_valid_o != 2'b00) begin
        resp_cnt++;
        resp_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("resp_unexpected", {30'd0, resp_valid_o}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_ch", {30'd0, resp_valid_o}, 32'(1 << e.ch));
          check("resp_paddr", resp_paddr_o, e.pa);
          check("resp_except", {31'd0, resp_except_o}, {31'd0, e.ex});
        end
      end
    end
  end

  task automatic do_req(input int ch, input logic [31:0] va, input logic [31:0] ep, input logic ee,
                        output int lat_o, output int mr_o);
    logic [1:0] m;
    int t0, n0, rc0;
    bit got;
    m = 2'(1 << ch);
    @(negedge clk);
    if (ch == 0) req_vaddr_i[31:0] = va; else req_vaddr_i[63:32] = va;
    req_i = req_i | m;
    exp_q.push_back('{ch, ep, ee});
    n0 = mem_reads; rc0 = resp_cnt; got = 1'b0; t0 = cyc;
    for (int i = 0; i < 50 && !got; i++) begin
      if ((req_ack_o & m) != 2'b00) begin got = 1'b1; t0 = cyc; end
      else @(negedge clk);
    end
    req_i = req_i & ~m;
    check("ack_seen", {31'd0, got}, 32'd1);
    for (int i = 0; i < 200 && resp_cnt == rc0; i++) @(negedge clk);
    check("resp_seen", 32'(resp_cnt - rc0), 32'd1);
    lat_o = resp_cyc - t0;
    mr_o  = mem_reads - n0;
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; req_i = 2'b00; req_vaddr_i = 64'd0; busy_mem_i = 1'b0;
    config_i = 32'd0; start_entry_cata = 32'h0010_0000;
    repeat (3) @(negedge clk);
    check("rst_ack", {30'd0, req_ack_o}, 32'd0);
    check("rst_resp_valid", {30'd0, resp_valid_o}, 32'd0);
    check("rst_paddr", resp_paddr_o, 32'd0);
    check("rst_except", {31'd0, resp_except_o}, 32'd0);
    check("rst_addr_mem", addr_mem_o, 32'd0);
    check("rst_valid_mem", {31'd0, valid_mem_o}, 32'd0);
    check("rst_state", {29'd0, state}, 32'd0);
    rst = 1'b0;

    // Bypass
    do_req(0, 32'h1234_5678, 32'h1234_5678, 1'b0, lat, mr);
    check("bypass_latency", lat, 32'd2);
    check("bypass_memreads", mr, 32'd0);

    // Miss then hit
    config_i = 32'd1;
    addr_q.delete();
    do_req(0, 32'h0040_3ABC, 32'h0ABC_DABC, 1'b0, lat, mr);
    check("miss_memreads", mr, 32'd2);
    check("miss_addr_count", addr_q.size(), 32'd2);
    if (addr_q.size() >= 2) begin
      check("miss_l1_addr", addr_q[0], 32'h0010_0004);
      check("miss_l2_addr", addr_q[1], 32'h0020_000C);
    end
    do_req(0, 32'h0040_3ABC, 32'h0ABC_DABC, 1'b0, lat, mr);
    check("hit_latency", lat, 32'd2);
    check("hit_memreads", mr, 32'd0);

    // Fault walks are never cached; ending on ch1 leaves the RR pointer at ch0
    do_req(0, 32'h0080_1000, 32'h0080_1000, 1'b1, lat, mr);
    check("fault_memreads", mr, 32'd1);
    do_req(1, 32'h0080_1000, 32'h0080_1000, 1'b1, lat, mr);
    check("fault_rewalk_memreads", mr, 32'd1);

    // Arbitration with both channels held
    config_i = 32'd0;
    r0 = resp_cnt;
    exp_q.push_back('{0, 32'h1111_0000, 1'b0});
    exp_q.push_back('{1, 32'h2222_0000, 1'b0});
    exp_q.push_back('{0, 32'h1111_0000, 1'b0});
    exp_q.push_back('{1, 32'h2222_0000, 1'b0});
    @(negedge clk);
    req_vaddr_i = {32'h2222_0000, 32'h1111_0000};
    req_i = 2'b11;
    k = 0;
    for (int i = 0; i < 60 && k < 4; i++) begin
      if (req_ack_o != 2'b00) begin
        check("arb_grant", {30'd0, req_ack_o}, (k % 2 == 0) ? 32'd1 : 32'd2);
        k++;
        if (k == 4) req_i = 2'b00;
      end
      if (k < 4) @(negedge clk);
    end
    req_i = 2'b00;
    check("arb_grant_count", k, 32'd4);
    for (int i = 0; i < 60 && resp_cnt < r0 + 4; i++) @(negedge clk);
    check("arb_resp_count", 32'(resp_cnt - r0), 32'd4);

    // Busy memory during L1_REQ
    config_i = 32'd1;
    busy_mem_i = 1'b1;
    fork
      do_req(0, 32'h0040_4123, 32'h0555_5123, 1'b0, lat, mr);
      begin
        logic [31:0] a0;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
          if (valid_mem_o) seen = 1'b1; else @(negedge clk);
        end
        check("busy_req_seen", {31'd0, seen}, 32'd1);
        a0 = addr_mem_o;
        check("busy_l1_addr", a0, 32'h0010_0004);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("busy_valid_hold", {31'd0, valid_mem_o}, 32'd1);
          check("busy_addr_hold", addr_mem_o, a0);
        end
        @(posedge clk); #1;
        busy_mem_i = 1'b0;
      end
    join
    check("busy_memreads", mr, 32'd2);

    // Flush coinciding with the refill edge in L2_WAIT
    fork
      do_req(0, 32'h0040_5000, 32'h0666_6000, 1'b0, lat, mr);
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
          @(negedge clk);
          if (state == 3'd5) seen = 1'b1;
        end
        check("flush_l2wait_seen", {31'd0, seen}, 32'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
      end
    join
    check("flush_walk_memreads", mr, 32'd2);
    do_req(0, 32'h0040_5000, 32'h0666_6000, 1'b0, lat, mr);
    check("flush_rewalk_memreads", mr, 32'd2);

    // Reset asserted in L1_WAIT
    @(negedge clk);
    req_vaddr_i[31:0] = 32'h0040_6000;
    req_i = 2'b01;
    k = 0;
    for (int i = 0; i < 20 && k == 0; i++) begin
      if (req_ack_o[0]) k = 1; else @(negedge clk);
    end
    req_i = 2'b00;
    k = 0;
    for (int i = 0; i < 20 && k == 0; i++) begin
      @(negedge clk);
      if (state == 3'd3) k = 1;
    end
    check("rst_l1wait_seen", k, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_valid_mem", {31'd0, valid_mem_o}, 32'd0);
    check("rst_async_state", {29'd0, state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_req(0, 32'h0040_3ABC, 32'h0ABC_DABC, 1'b0, lat, mr);
    check("post_rst_memreads", mr, 32'd2);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
